// File: rtl/studio2_keypad.sv
// studio2_keypad: Studio II keypad interface.
// Latches the key-select nibble written by the CPU OUT instruction, synchronises
// the two 10-key pads and drives EF3 (pad A) / EF4 (pad B) with the selected key.
// Build option: define KEYPAD_DEBOUNCE_EN to add per-key debounce counters
// sampled on ce; without it the synchroniser output is used directly.
module studio2_keypad #(
  parameter logic [2:0] KEY_PORT  = 3'd2,
  parameter int         DEB_W     = 4,
  parameter int         DEB_COUNT = 10
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       ce,
  input  logic       io_out,
  input  logic [2:0] io_n,
  input  logic [7:0] io_dout,
  input  logic [9:0] keys_a,
  input  logic [9:0] keys_b,
  output logic [3:0] key_sel,
  output logic [3:0] ef
);

  localparam int NKEYS = 20;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);

  logic [3:0]       key_sel_q, key_sel_d;
  logic [3:0]       ef_q, ef_d;
  logic [NKEYS-1:0] sync1_q, sync1_d;
  logic [NKEYS-1:0] sync2_q, sync2_d;
  logic [NKEYS-1:0] stable;
  logic [9:0]       stable_a, stable_b;
  logic             unused_bits;

  // Key-select latch: only an OUT to the keypad port loads the low nibble.
  always_comb begin
    key_sel_d = key_sel_q;
    if (io_out && (io_n == KEY_PORT)) begin
      key_sel_d = io_dout[3:0];
    end
  end

  // Two-stage synchroniser inputs; pad B occupies the upper ten bits.
  always_comb begin
    sync1_d = {keys_b, keys_a};
    sync2_d = sync1_q;
  end

`ifdef KEYPAD_DEBOUNCE_EN
  logic [NKEYS-1:0] stable_q, stable_d;
  logic [DEB_W-1:0] cnt_q [NKEYS];
  logic [DEB_W-1:0] cnt_d [NKEYS];

  // Per-key debounce: a key must disagree with its stable state for DEB_COUNT
  // consecutive ce samples before it flips; any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (ce) begin
      for (int i = 0; i < NKEYS; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      stable_q <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable      = stable_q;
  assign unused_bits = ^io_dout[7:4];
`else
  // Without debounce the synchroniser output is the stable key state.
  assign stable      = sync2_q;
  assign unused_bits = ^{io_dout[7:4], ce, DEB_LAST};
`endif

  assign stable_a = stable[9:0];
  assign stable_b = stable[19:10];

  // EF mapping: selections 10..15 address no key and read as released.
  always_comb begin
    ef_d = 4'b0000;
    if (key_sel_q <= 4'd9) begin
      ef_d[2] = stable_a[key_sel_q];
      ef_d[3] = stable_b[key_sel_q];
    end
  end

  // Latch, synchroniser and EF registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      key_sel_q <= '0;
      ef_q      <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      key_sel_q <= key_sel_d;
      ef_q      <= ef_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
    end
  end

  assign key_sel = key_sel_q;
  assign ef      = ef_q;

endmodule
